uart_param_top: RTL

Parametrised UART with configurable character format, runtime baud divisor and independent TX/RX FIFOs.
Successor to the fixed 8N1 uart_top. Adds parity, 1/2 stop bits, 16x oversampled RX with false-start rejection, and sticky error flags.
Sits between the host-side byte stream of the image-transfer path and the board serial pins.

---
 rtl/uart_param_top.sv | 310 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_param_top.sv
// Parametrised UART: 5..8 data bits, optional parity, 1 or 2 stop bits, runtime baud divisor,
// 16x oversampled receiver with false-start rejection, sticky error flags and TX/RX FIFOs.
module uart_param_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr,
   input  logic [W-1:0] wr_data,
   input  logic         rd,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          wr_en, rd_en;

   always_comb begin
      full     = (count_q == FULL_CNT);
      empty    = (count_q == '0);
      wr_en    = wr & ~full;
      rd_en    = rd & ~empty;
      wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (wr_en && !rd_en) count_d = count_q + (AW+1)'(1);
      else if (rd_en && !wr_en) count_d = count_q - (AW+1)'(1);
      // Show-ahead head reads as zero while empty so the output is defined after reset.
      rd_data  = empty ? '0 : mem_q[rd_ptr_q];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_data;
   end
endmodule

module uart_param_top #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DIV_WIDTH-1:0] baud_div,
   output logic                 tx,
   input  logic                 rx,
   input  logic [DATA_BITS-1:0] tx_wr_data,
   input  logic                 tx_wr,
   output logic                 tx_full,
   output logic                 tx_done,
   output logic [DATA_BITS-1:0] rx_rd_data,
   output logic                 rx_valid,
   input  logic                 rx_rd,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   input  logic                 err_clr
);
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
   localparam logic       ODD       = (PARITY_ODD != 0);
   localparam logic       PAR       = (PARITY_EN != 0);

   // ---------------- transmitter ----------------
   state_t                tx_state_q, tx_state_d;
   logic [DIV_WIDTH-1:0]  tx_div_q, tx_div_d, tx_lat_q, tx_lat_d;
   logic [3:0]            tx_tick_q, tx_tick_d;
   logic [2:0]            tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0]  tx_sh_q, tx_sh_d, tx_head;
   logic                  tx_par_q, tx_par_d, tx_q, tx_d, tx_done_q, tx_done_d;
   logic                  tx_tick, tx_bit_end, tx_pop, tx_empty;

   uart_param_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .rst(rst), .wr(tx_wr), .wr_data(tx_wr_data), .rd(tx_pop),
      .rd_data(tx_head), .full(tx_full), .empty(tx_empty)
   );

   always_comb begin
      tx_state_d = tx_state_q;
      tx_lat_d   = tx_lat_q;
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      tx_par_d   = tx_par_q;
      tx_pop     = 1'b0;
      tx_done_d  = 1'b0;
      tx_tick    = (tx_div_q == tx_lat_q);
      tx_bit_end = tx_tick && (tx_tick_q == 4'd15);
      tx_div_d   = tx_tick ? '0 : tx_div_q + DIV_WIDTH'(1);
      tx_tick_d  = tx_tick ? tx_tick_q + 4'd1 : tx_tick_q;
      case (tx_state_q)
         S_IDLE: begin
            tx_div_d  = '0;
            tx_tick_d = '0;
            tx_pop    = !tx_empty;
         end
         S_START: if (tx_bit_end) begin
            tx_state_d = S_DATA;
            tx_bit_d   = '0;
         end
         S_DATA: if (tx_bit_end) begin
            tx_sh_d  = tx_sh_q >> 1;
            tx_bit_d = tx_bit_q + 3'd1;
            if (tx_bit_q == LAST_DATA) begin
               tx_state_d = PAR ? S_PARITY : S_STOP;
               tx_bit_d   = '0;
            end
         end
         S_PARITY: if (tx_bit_end) begin
            tx_state_d = S_STOP;
            tx_bit_d   = '0;
         end
         S_STOP: if (tx_bit_end) begin
            tx_bit_d = tx_bit_q + 3'd1;
            if (tx_bit_q == LAST_STOP) begin
               tx_done_d  = 1'b1;
               tx_state_d = S_IDLE;
               tx_pop     = !tx_empty;
            end
         end
         default: tx_state_d = S_IDLE;
      endcase
      // A pop always starts a frame, either from idle or straight out of the last stop bit.
      if (tx_pop) begin
         tx_state_d = S_START;
         tx_sh_d    = tx_head;
         tx_par_d   = (^tx_head) ^ ODD;
         tx_lat_d   = baud_div;
         tx_div_d   = '0;
         tx_tick_d  = '0;
         tx_bit_d   = '0;
      end
      tx_d = 1'b1;
      case (tx_state_q)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = tx_sh_q[0];
         S_PARITY: tx_d = tx_par_q;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state_q <= S_IDLE;
         tx_div_q   <= '0;
         tx_lat_q   <= '0;
         tx_tick_q  <= '0;
         tx_bit_q   <= '0;
         tx_sh_q    <= '0;
         tx_par_q   <= 1'b0;
         tx_q       <= 1'b1;
         tx_done_q  <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_div_q   <= tx_div_d;
         tx_lat_q   <= tx_lat_d;
         tx_tick_q  <= tx_tick_d;
         tx_bit_q   <= tx_bit_d;
         tx_sh_q    <= tx_sh_d;
         tx_par_q   <= tx_par_d;
         tx_q       <= tx_d;
         tx_done_q  <= tx_done_d;
      end
   end

   assign tx      = tx_q;
   assign tx_done = tx_done_q;

   // ---------------- receiver ----------------
   state_t                rx_state_q, rx_state_d;
   logic [DIV_WIDTH-1:0]  rx_div_q, rx_div_d, rx_lat_q, rx_lat_d;
   logic [3:0]            rx_tick_q, rx_tick_d;
   logic [2:0]            rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0]  rx_sh_q, rx_sh_d;
   logic                  rx_s1_q, rx_s2_q, rx_s3_q;
   logic                  rx_serr_q, rx_serr_d, rx_pbad_q, rx_pbad_d;
   logic                  perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
   logic                  rx_tick, rx_sample, rx_fall, rx_push, rx_full, rx_empty;
   logic                  set_perr, set_ferr, set_ovr;

   uart_param_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .rst(rst), .wr(rx_push), .wr_data(rx_sh_q), .rd(rx_rd),
      .rd_data(rx_rd_data), .full(rx_full), .empty(rx_empty)
   );

   always_comb begin
      rx_state_d = rx_state_q;
      rx_lat_d   = rx_lat_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_serr_d  = rx_serr_q;
      rx_pbad_d  = rx_pbad_q;
      rx_push    = 1'b0;
      set_perr   = 1'b0;
      set_ferr   = 1'b0;
      set_ovr    = 1'b0;
      rx_fall    = rx_s3_q & ~rx_s2_q;
      rx_tick    = (rx_div_q == rx_lat_q);
      // Every decision is taken at mid-bit, so state changes land 16 ticks apart.
      rx_sample  = rx_tick && (rx_tick_q == 4'd7);
      rx_div_d   = rx_tick ? '0 : rx_div_q + DIV_WIDTH'(1);
      rx_tick_d  = rx_tick ? rx_tick_q + 4'd1 : rx_tick_q;
      case (rx_state_q)
         S_IDLE: begin
            rx_div_d  = '0;
            rx_tick_d = '0;
            if (rx_fall) begin
               rx_state_d = S_START;
               rx_lat_d   = baud_div;
            end
         end
         S_START: if (rx_sample) begin
            rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
            rx_bit_d   = '0;
            rx_serr_d  = 1'b0;
            rx_pbad_d  = 1'b0;
         end
         S_DATA: if (rx_sample) begin
            rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
            rx_bit_d = rx_bit_q + 3'd1;
            if (rx_bit_q == LAST_DATA) begin
               rx_state_d = PAR ? S_PARITY : S_STOP;
               rx_bit_d   = '0;
            end
         end
         S_PARITY: if (rx_sample) begin
            rx_pbad_d  = rx_s2_q ^ (^rx_sh_q) ^ ODD;
            rx_state_d = S_STOP;
            rx_bit_d   = '0;
         end
         S_STOP: if (rx_sample) begin
            rx_bit_d = rx_bit_q + 3'd1;
            if (rx_bit_q == LAST_STOP) begin
               rx_state_d = S_IDLE;
               if (rx_serr_q || !rx_s2_q) set_ferr = 1'b1;
               else if (rx_pbad_q)        set_perr = 1'b1;
               else if (rx_full)          set_ovr  = 1'b1;
               else                       rx_push  = 1'b1;
            end else begin
               rx_serr_d = rx_serr_q | ~rx_s2_q;
            end
         end
         default: rx_state_d = S_IDLE;
      endcase
      perr_d = set_perr | (perr_q & ~err_clr);
      ferr_d = set_ferr | (ferr_q & ~err_clr);
      ovr_d  = set_ovr  | (ovr_q  & ~err_clr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state_q <= S_IDLE;
         rx_div_q   <= '0;
         rx_lat_q   <= '0;
         rx_tick_q  <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_s3_q    <= 1'b1;
         rx_serr_q  <= 1'b0;
         rx_pbad_q  <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_div_q   <= rx_div_d;
         rx_lat_q   <= rx_lat_d;
         rx_tick_q  <= rx_tick_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
         rx_s1_q    <= rx;
         rx_s2_q    <= rx_s1_q;
         rx_s3_q    <= rx_s2_q;
         rx_serr_q  <= rx_serr_d;
         rx_pbad_q  <= rx_pbad_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         ovr_q      <= ovr_d;
      end
   end

   assign rx_valid   = ~rx_empty;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;
endmodule
